// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared owner-state type and default sizing for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_N_DEFAULT         = 1024;
  localparam int DMEM_MAX_BURST_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    LD_OWN  = 2'd2
  } owner_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_addr_check.sv
// rtl/dmem_arbiter_addr_check.sv - word-aligned, in-range address compare for the data memory
module dmem_addr_check
  import dmem_arbiter_pkg::*;
#(
  parameter int N = DMEM_N_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        legal
);

  localparam logic [31:0] LAST_WORD = 32'(N - 4);

  // A beat is legal when it is word aligned and the whole word fits in memory
  always_comb begin
    legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / loader arbiter in front of a single-port data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N         = DMEM_N_DEFAULT,
  parameter int MAX_BURST = DMEM_MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_last,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic [31:0] rdata,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  output logic        m_we,
  input  logic [31:0] m_rd,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int            CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  owner_t        state;
  owner_t        state_nx;
  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          yield;
  logic          legal;
  logic          fault;

  // The loader is cut off only once it has used its allowance and the CPU is waiting
  assign yield = (state == LD_OWN) && (burst_cnt == BURST_LIMIT) && c_req;

  // State register, tie-break history and loader burst counter (saturates at the limit)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWNER_LD;
      burst_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state && state_nx == CPU_OWN) begin
        last_owner <= OWNER_CPU;
      end else if (state_nx != state && state_nx == LD_OWN) begin
        last_owner <= OWNER_LD;
      end
      if (state_nx == LD_OWN && state != LD_OWN) begin
        burst_cnt <= '0;
      end else if (l_gnt && burst_cnt != BURST_LIMIT) begin
        burst_cnt <= burst_cnt + CW'(1);
      end
    end
  end

  // Next owner: ties go to whoever did not own last, the loader leaves on last beat, yield or drop
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (c_req && l_req) begin
          state_nx = (last_owner == OWNER_LD) ? CPU_OWN : LD_OWN;
        end else if (c_req) begin
          state_nx = CPU_OWN;
        end else if (l_req) begin
          state_nx = LD_OWN;
        end
      end
      CPU_OWN: begin
        if (!c_req) begin
          state_nx = l_req ? LD_OWN : IDLE;
        end
      end
      LD_OWN: begin
        if (yield) begin
          state_nx = CPU_OWN;
        end else if (!l_req) begin
          state_nx = IDLE;
        end else if (l_last) begin
          state_nx = c_req ? CPU_OWN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory address/data follow the loader only while it owns the port
  always_comb begin
    m_a  = c_addr;
    m_wd = c_wdata;
    if (state == LD_OWN) begin
      m_a  = l_addr;
      m_wd = l_wdata;
    end
  end

  dmem_addr_check #(
    .N (N)
  ) u_addr_check (
    .addr  (m_a),
    .legal (legal)
  );

  // Grants and write strobe; everything is held off while reset is asserted
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    m_we  = 1'b0;
    if (rst) begin
      c_gnt = (state == CPU_OWN) && c_req;
      l_gnt = (state == LD_OWN) && l_req && !yield;
      m_we  = legal && ((c_gnt && c_we) || (l_gnt && l_we));
    end
  end

  assign rdata = m_rd;
  assign fault = (c_gnt || l_gnt) && !legal;

  // Sticky error keeps the first faulting address; a fault coincident with a clear restarts capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (fault) begin
      err <= 1'b1;
      if (!err || err_clr) begin
        err_addr <= m_a;
      end
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N, default 1024: data memory size in bytes; legal word addresses are 0..N-4.
REQ-002 Parameter MAX_BURST, default 8: maximum consecutive loader beats while a CPU request is pending.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 c_req / c_we  in  1 / 1  CPU access request / write enable.
REQ-006 c_addr / c_wdata  in  32 / 32  CPU byte address / write data.
REQ-007 c_gnt  out  1  CPU beat accepted this cycle.
REQ-008 l_req / l_we / l_last  in  1 / 1 / 1  loader request / write enable / final beat of burst.
REQ-009 l_addr / l_wdata  in  32 / 32  loader byte address / write data.
REQ-010 l_gnt  out  1  loader beat accepted this cycle.
REQ-011 rdata  out  32  read data from m_rd, shared by both requesters, valid in the cycle the requester's gnt is high.
REQ-012 m_a / m_wd / m_we  out  32 / 32 / 1  memory address / write data / write enable.
REQ-013 m_rd  in  32  combinational memory read data.
REQ-014 err_clr  in  1  clears the sticky error.
REQ-015 err / err_addr  out  1 / 32  sticky access error / address of the first faulting beat.

Function
REQ-016 The FSM SHALL have states IDLE, CPU_OWN and LD_OWN; it SHALL hold a last_owner bit and a burst counter of width clog2(MAX_BURST+1).
REQ-017 IDLE: c_req only -> CPU_OWN; l_req only -> LD_OWN; both -> the owner opposite last_owner; neither -> IDLE; no grant is issued in IDLE.
REQ-018 In CPU_OWN, c_gnt SHALL equal c_req combinationally; if c_req is low, next state SHALL be LD_OWN when l_req is high, else IDLE.
REQ-019 In LD_OWN, l_gnt SHALL equal l_req combinationally; each granted beat SHALL increment the burst counter.
REQ-020 LD_OWN SHALL exit after a granted beat with l_last=1: to CPU_OWN if c_req is high, else IDLE.
REQ-021 LD_OWN SHALL exit on forced yield when the counter reaches MAX_BURST and c_req is high: to CPU_OWN, l_gnt low from that cycle.
REQ-022 LD_OWN SHALL go to IDLE when l_req is low.
REQ-023 The burst counter SHALL clear on every entry to LD_OWN.
REQ-024 last_owner SHALL update on every transition into CPU_OWN or LD_OWN.
REQ-025 m_a/m_wd SHALL mux the granted requester's address/data (CPU in CPU_OWN or IDLE, loader in LD_OWN).
REQ-026 m_we SHALL be high only for a granted beat with we=1 and a legal address; a write commits at the edge ending that cycle.
REQ-027 Legal address SHALL mean addr[1:0]==0 and unsigned addr <= N-4.
REQ-028 A granted illegal beat SHALL still complete its handshake (gnt high), suppress m_we, and set err next edge.
REQ-029 err_addr SHALL capture the faulting address only when err is low.
REQ-030 err_clr SHALL clear err; a new error in the same cycle wins (err stays set, err_addr reloads).
REQ-031 c_gnt and l_gnt SHALL never be high in the same cycle.

Reset
REQ-032 While rst=0 at an edge: state=IDLE, last_owner=loader (CPU wins the first tie), counter=0, err=0, err_addr=0.
REQ-033 While rst=0, c_gnt=l_gnt=m_we=0; reset mid-burst SHALL drop ownership without completing the beat.

Structure
REQ-034 A shared package SHALL hold the owner-state enum {IDLE, CPU_OWN, LD_OWN} and the default N/MAX_BURST constants.
REQ-035 One sub-module, dmem_addr_check (legal-address compare, parameter N), SHALL be instantiated once on the muxed address.

Verification
REQ-036 After reset, both req at once, write addr 0x10 -> first cycle idle, then c_gnt for the CPU beat; loader granted after c_req drops.
REQ-037 Loader burst of 12 writes from 0x0, c_req raised at beat 2 -> 8 l_gnt beats, then CPU_OWN; loader resumes after the CPU releases.
REQ-038 CPU write to 0x6 -> c_gnt=1, m_we=0, err=1, err_addr=0x6; a second fault at 0x400 leaves err_addr=0x6.
REQ-039 err_clr together with a faulting loader beat at N-2 -> err stays 1, err_addr=N-2.
REQ-040 rst low during LD_OWN beat 3 -> next cycle IDLE, no grant, no m_we, counter=0.
REQ-041 CPU reads 0x20 after loader wrote 0xDEADBEEF there -> rdata=0xDEADBEEF in the c_gnt cycle.
